// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and NZCV flag bundle shared by alu_mc.
// The MUL opcode is only decoded when ALU_MUL_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add multiplier, one partial product per cycle.
// Built only when ALU_MUL_EN is defined; done marks the final step's cycle.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    // The last step's sum is handed out directly so it lands on the count-to-zero edge
    assign done    = (cnt_q == CW'(1));
    assign product = acc_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU with registered result and NZCV flags held until consumed.
// Define ALU_MUL_EN to add the iterative MUL (opcode 1100) and its BUSY state.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [3:0]       ALUCtrl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] busw_q, busw_d;
    flags_t           flags_q, flags_d;

    logic [WIDTH-1:0] res;
    logic             res_c, res_v;
    logic [WIDTH:0]   add_w;
    logic [SHW-1:0]   sh;
    logic             accept;

    assign sh     = BusB[SHW-1:0];
    assign add_w  = {1'b0, BusA} + {1'b0, BusB};
    assign accept = InValid && InReady;

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (1'b1)
            (ALUCtrl == OP_AND):   res = BusA & BusB;
            (ALUCtrl == OP_OR):    res = BusA | BusB;
            (ALUCtrl == OP_XOR):   res = BusA ^ BusB;
            (ALUCtrl == OP_PASSB): res = BusB;
            (ALUCtrl == OP_ADD): begin
                res   = add_w[WIDTH-1:0];
                res_c = add_w[WIDTH];
                res_v = (BusA[WIDTH-1] == BusB[WIDTH-1]) &&
                        (res[WIDTH-1] != BusA[WIDTH-1]);
            end
            (ALUCtrl == OP_SUB): begin
                res   = BusA - BusB;
                res_c = (BusA >= BusB);
                res_v = (BusA[WIDTH-1] != BusB[WIDTH-1]) &&
                        (res[WIDTH-1] != BusA[WIDTH-1]);
            end
            (ALUCtrl == OP_SLL):   res = BusA << sh;
            (ALUCtrl == OP_SRL):   res = BusA >> sh;
            (ALUCtrl == OP_SRA):   res = $signed(BusA) >>> sh;
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign mul_start = accept && (ALUCtrl == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (Clk),
        .rst_n   (ResetL),
        .start   (mul_start),
        .a       (BusA),
        .b       (BusB),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_comb begin
        state_d = state_q;
        busw_d  = busw_q;
        flags_d = flags_q;
        case (state_q)
            ST_DONE: if (OutReady) state_d = ST_IDLE;
`ifdef ALU_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_d   = ST_DONE;
                    busw_d    = mul_prod;
                    flags_d.z = (mul_prod == '0);
                    flags_d.n = mul_prod[WIDTH-1];
                    flags_d.c = 1'b0;
                    flags_d.v = 1'b0;
                end
            end
`endif
            default: ;
        endcase
        if (accept) begin
            state_d   = ST_DONE;
            busw_d    = res;
            flags_d.z = (res == '0);
            flags_d.n = res[WIDTH-1];
            flags_d.c = res_c;
            flags_d.v = res_v;
`ifdef ALU_MUL_EN
            if (ALUCtrl == OP_MUL) state_d = ST_BUSY;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            state_q <= ST_IDLE;
            busw_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            busw_q  <= busw_d;
            flags_q <= flags_d;
        end
    end

    assign InReady  = ResetL && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && OutReady));
    assign OutValid = (state_q == ST_DONE);
    assign BusW     = busw_q;
    assign Zero     = flags_q.z;
    assign Negative = flags_q.n;
    assign Carry    = flags_q.c;
    assign Overflow = flags_q.v;

endmodule
